// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer/flag controller of the async FIFO: binary and Gray write
// pointers, read-pointer synchroniser, full / almost-full / level / overflow.
module fifo_wr_ptr_full #(
    parameter int ADDRESS      = 4,
    parameter int DEPTH        = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic               W_CLK,
    input  logic               W_RST,
    input  logic               W_INC,
    input  logic [ADDRESS-1:0] R_GRAY_PTR,
    output logic [ADDRESS-2:0] W_ADDR,
    output logic [ADDRESS-1:0] W_GRAY_PTR,
    output logic               W_FULL,
    output logic               W_AFULL,
    output logic [ADDRESS-1:0] W_LEVEL,
    output logic               W_OVERFLOW
);

    localparam logic [ADDRESS-1:0] AFULL_T = ADDRESS'(AFULL_THRESH);

    logic [SYNC_STAGES-1:0][ADDRESS-1:0] sync_q;
    logic [ADDRESS-1:0] wbin, wbin_n, wgray_n, rq, rbin, level_n, full_cmp;
    logic               winc_ok;

    assign W_ADDR   = wbin[$clog2(DEPTH)-1:0];
    assign rq       = sync_q[SYNC_STAGES-1];
    assign winc_ok  = W_INC & ~W_FULL;
    assign wbin_n   = wbin + {{(ADDRESS-1){1'b0}}, winc_ok};
    assign wgray_n  = wbin_n ^ (wbin_n >> 1);
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_cmp = {~rq[ADDRESS-1:ADDRESS-2], rq[ADDRESS-3:0]};
    assign level_n  = wbin_n - rbin;

    always_comb begin
        rbin = '0;
        for (int i = 0; i < ADDRESS; i++)
            rbin[i] = ^(rq >> i);
    end

    // Pure flop chain; nothing combinational may sit between stages.
    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], R_GRAY_PTR};
    end

    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            wbin       <= '0;
            W_GRAY_PTR <= '0;
            W_FULL     <= 1'b0;
            W_AFULL    <= 1'b0;
            W_LEVEL    <= '0;
            W_OVERFLOW <= 1'b0;
        end else begin
            wbin       <= wbin_n;
            W_GRAY_PTR <= wgray_n;
            W_FULL     <= (wgray_n == full_cmp);
            W_AFULL    <= (level_n >= AFULL_T);
            W_LEVEL    <= level_n;
            W_OVERFLOW <= W_OVERFLOW | (W_INC & W_FULL);
        end
    end

endmodule
